// File: rtl/spi_master_datapath_pkg.sv
// spi_master_datapath_pkg: shared defaults and width helper for the SPI master datapath and its FSM
package spi_master_datapath_pkg;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_MSG_WIDTH  = 8;
  localparam int DEF_NUM_MSGS   = 4;
  localparam int DEF_GAP_CYCLES = 8;
  function automatic int clog2w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: free-running SCLK divider; clock/reset in, sclk_in phase plus high_t/low_t one-cycle-early edge strobes out
module spi_clk_div
  import spi_master_datapath_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic sclk_in,
  output logic low_t,
  output logic high_t
);
  localparam int DW = clog2w(CLK_DIV);
  logic [DW-1:0] r_div_cnt;
  logic          r_sclk;
  logic          w_tc;
  assign w_tc    = r_div_cnt == DW'(CLK_DIV - 1);
  assign sclk_in = r_sclk;
  assign high_t  = w_tc && !r_sclk;
  assign low_t   = w_tc && r_sclk;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_tc ? '0 : r_div_cnt + DW'(1);
      r_sclk    <= r_sclk ^ w_tc;
    end
endmodule

// File: rtl/spi_master_datapath.sv
// spi_master_datapath: message buffer, bit/message indices, go/busy handshake and gap timer feeding the SPI master FSM (host: wr_*/go/len/busy/done; FSM: inc_bit/inc_msg/waiting in, start/sclk_in/low_t/high_t/msg_bit/last_bit/last_msg/restart out)
module spi_master_datapath
  import spi_master_datapath_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int MSG_WIDTH  = DEF_MSG_WIDTH,
  parameter int NUM_MSGS   = DEF_NUM_MSGS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [clog2w(NUM_MSGS)-1:0]        wr_addr,
  input  logic [MSG_WIDTH-1:0]               wr_data,
  input  logic                               go,
  input  logic [clog2w(NUM_MSGS+1)-1:0]      len,
  output logic                               busy,
  output logic                               done,
  input  logic                               inc_bit,
  input  logic                               inc_msg,
  input  logic                               waiting,
  output logic                               start,
  output logic                               sclk_in,
  output logic                               low_t,
  output logic                               high_t,
  output logic                               msg_bit,
  output logic                               last_bit,
  output logic                               last_msg,
  output logic                               restart
);
  localparam int AW = clog2w(NUM_MSGS);
  localparam int LW = clog2w(NUM_MSGS + 1);
  localparam int BW = clog2w(MSG_WIDTH);
  localparam int GW = clog2w(GAP_CYCLES);
  logic [MSG_WIDTH-1:0] r_buf [NUM_MSGS];
  logic                 r_busy, r_done, r_start;
  logic [BW-1:0]        r_bit_idx, w_bit_nxt;
  logic [AW-1:0]        r_msg_idx, w_msg_nxt;
  logic [LW-1:0]        r_len_q;
  logic [GW-1:0]        r_gap_cnt;
  logic                 w_go_ok, w_last_bit, w_last_msg, w_end, w_gap_top, w_slot_top;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock  (clock),
    .reset  (reset),
    .sclk_in(sclk_in),
    .low_t  (low_t),
    .high_t (high_t)
  );
  assign w_go_ok    = go && !r_busy && len != '0 && len <= LW'(NUM_MSGS);
  assign w_last_bit = r_bit_idx == BW'(MSG_WIDTH - 1);
  assign w_last_msg = r_busy && (LW'(r_msg_idx) + LW'(1) == r_len_q);
  assign w_end      = inc_msg && w_last_msg;
  assign w_slot_top = r_msg_idx == AW'(NUM_MSGS - 1);
  assign w_gap_top  = r_gap_cnt == GW'(GAP_CYCLES - 1);
  always_comb begin
    w_bit_nxt = (w_go_ok || inc_msg) ? '0 : inc_bit ? (w_last_bit ? '0 : r_bit_idx + BW'(1)) : r_bit_idx;
    w_msg_nxt = (w_go_ok || (inc_msg && (w_last_msg || w_slot_top))) ? '0 : inc_msg ? r_msg_idx + AW'(1) : r_msg_idx;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_MSGS; i++) r_buf[i] <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_start   <= 1'b0;
      r_bit_idx <= '0;
      r_msg_idx <= '0;
      r_len_q   <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (wr_en && !r_busy) r_buf[wr_addr] <= wr_data;
      r_busy    <= w_go_ok ? 1'b1 : w_end ? 1'b0 : r_busy;
      r_done    <= w_end;
      r_start   <= w_go_ok;
      r_len_q   <= w_go_ok ? len : r_len_q;
      r_bit_idx <= w_bit_nxt;
      r_msg_idx <= w_msg_nxt;
      r_gap_cnt <= !waiting ? '0 : w_gap_top ? r_gap_cnt : r_gap_cnt + GW'(1);
    end
  assign busy     = r_busy;
  assign done     = r_done;
  assign start    = r_start;
  assign msg_bit  = r_buf[r_msg_idx][BW'(MSG_WIDTH - 1) - r_bit_idx];
  assign last_bit = w_last_bit;
  assign last_msg = w_last_msg;
  assign restart  = waiting && w_gap_top;
endmodule

// File: tb/tb_spi_master_datapath.sv
// tb_spi_master_datapath: scoreboard bench for the SPI master datapath at CLK_DIV=2, MSG_WIDTH=8, NUM_MSGS=4, GAP_CYCLES=3
module tb_spi_master_datapath;
  logic       clock = 1'b0, reset = 1'b1, wr_en = 1'b0, go = 1'b0;
  logic       inc_bit = 1'b0, inc_msg = 1'b0, waiting = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] len = '0;
  logic       busy, done, start, sclk_in, low_t, high_t, msg_bit, last_bit, last_msg, restart;
  int         errors = 0, checks = 0;
  logic [7:0] model [4] = '{default: 8'h00};
  bit         exp_q [$];
  bit         lm_q [$];
  spi_master_datapath #(.CLK_DIV(2), .MSG_WIDTH(8), .NUM_MSGS(4), .GAP_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .len(len), .busy(busy), .done(done), .inc_bit(inc_bit), .inc_msg(inc_msg),
    .waiting(waiting), .start(start), .sclk_in(sclk_in), .low_t(low_t), .high_t(high_t),
    .msg_bit(msg_bit), .last_bit(last_bit), .last_msg(last_msg), .restart(restart)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic test_reset;
    logic [2:0] exp;
    @(negedge clock); #1;
    checks++; if ({busy, done, start, sclk_in, low_t, high_t, msg_bit, last_bit, last_msg, restart} !== 10'b0) begin errors++; $display("FAIL reset_outputs got %b exp 0", {busy, done, start, sclk_in, low_t, high_t, msg_bit, last_bit, last_msg, restart}); end
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      exp = {c % 4 >= 2, c % 4 == 1, c % 4 == 3};
      checks++; if ({sclk_in, high_t, low_t} !== exp) begin errors++; $display("FAIL divider c=%0d got %b exp %b", c, {sclk_in, high_t, low_t}, exp); end
    end
  endtask
  task automatic test_bit_serial;
    bit e;
    @(negedge clock); wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hA5; model[0] = 8'hA5;
    @(negedge clock); wr_en = 1'b0; go = 1'b1; len = 3'd1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(model[0][i]);
    exp_q.push_back(model[0][7]);
    @(negedge clock); go = 1'b0; #1;
    checks++; if ({start, busy} !== 2'b11) begin errors++; $display("FAIL go_accept got %b exp 11", {start, busy}); end
    @(negedge clock); #1;
    checks++; if ({start, busy} !== 2'b01) begin errors++; $display("FAIL start_pulse got %b exp 01", {start, busy}); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clock); inc_bit = i < 8; #1;
      e = exp_q.pop_front();
      checks++; if (msg_bit !== e) begin errors++; $display("FAIL msg_bit i=%0d got %b exp %b", i, msg_bit, e); end
      checks++; if (last_bit !== (i == 7)) begin errors++; $display("FAIL last_bit i=%0d got %b exp %b", i, last_bit, i == 7); end
    end
    @(negedge clock); inc_bit = 1'b0; inc_msg = 1'b1; #1;
    checks++; if (last_msg !== 1'b1) begin errors++; $display("FAIL last_msg_single got %b exp 1", last_msg); end
    @(negedge clock); inc_msg = 1'b0; #1;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL burst_end got %b exp 01", {busy, done}); end
    @(negedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", done); end
  endtask
  task automatic test_msg_index;
    bit e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'(i + 1); model[i] = 8'(i + 1);
    end
    @(negedge clock); wr_en = 1'b0; go = 1'b1; len = 3'd3;
    for (int i = 0; i < 3; i++) lm_q.push_back(i == 2);
    @(negedge clock); go = 1'b0; #1;
    checks++; if ({start, busy} !== 2'b11) begin errors++; $display("FAIL go3_accept got %b exp 11", {start, busy}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); inc_msg = 1'b1; #1;
      e = lm_q.pop_front();
      checks++; if (last_msg !== e) begin errors++; $display("FAIL last_msg idx=%0d got %b exp %b", i, last_msg, e); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid idx=%0d got %b exp 1", i, busy); end
      checks++; if (msg_bit !== model[i][7]) begin errors++; $display("FAIL msg_msb idx=%0d got %b exp %b", i, msg_bit, model[i][7]); end
    end
    @(negedge clock); inc_msg = 1'b0; #1;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL burst3_end got %b exp 01", {busy, done}); end
    @(negedge clock); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL done3_width got %b exp 00", {busy, done}); end
  endtask
  task automatic test_gap;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clock); waiting = 1'b1; #1;
      checks++; if (restart !== (j >= 3)) begin errors++; $display("FAIL restart j=%0d got %b exp %b", j, restart, j >= 3); end
    end
    @(negedge clock); waiting = 1'b0; #1;
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_drop got %b exp 0", restart); end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clock); waiting = 1'b1; #1;
      checks++; if (restart !== (j == 3)) begin errors++; $display("FAIL gap_cleared j=%0d got %b exp %b", j, restart, j == 3); end
    end
    @(negedge clock); waiting = 1'b0;
  endtask
  task automatic test_illegal_go;
    logic [2:0] bad [2] = '{3'd0, 3'd5};
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); go = 1'b1; len = bad[k];
      @(negedge clock); go = 1'b0; #1;
      checks++; if ({start, busy} !== 2'b00) begin errors++; $display("FAIL bad_len=%0d got %b exp 00", bad[k], {start, busy}); end
    end
    @(negedge clock); go = 1'b1; len = 3'd2;
    @(negedge clock); go = 1'b1; len = 3'd1; #1;
    checks++; if ({start, busy} !== 2'b11) begin errors++; $display("FAIL go2_accept got %b exp 11", {start, busy}); end
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    @(negedge clock); go = 1'b0; wr_en = 1'b0; #1;
    checks++; if ({start, busy} !== 2'b01) begin errors++; $display("FAIL go_busy got %b exp 01", {start, busy}); end
    checks++; if (last_msg !== 1'b0) begin errors++; $display("FAIL len_relatched got %b exp 0", last_msg); end
    checks++; if (msg_bit !== model[0][7]) begin errors++; $display("FAIL wr_while_busy got %b exp %b", msg_bit, model[0][7]); end
  endtask
  task automatic test_reset_mid_burst;
    logic [2:0] exp;
    bit e;
    @(negedge clock); inc_msg = 1'b1; #1;
    checks++; if (last_msg !== 1'b0) begin errors++; $display("FAIL mid_last_msg0 got %b exp 0", last_msg); end
    @(negedge clock); inc_msg = 1'b0; inc_bit = 1'b1;
    repeat (3) @(negedge clock);
    @(negedge clock); inc_bit = 1'b0; #1;
    checks++; if ({last_msg, last_bit} !== 2'b10) begin errors++; $display("FAIL mid_pos got %b exp 10", {last_msg, last_bit}); end
    checks++; if (msg_bit !== model[1][3]) begin errors++; $display("FAIL mid_bit got %b exp %b", msg_bit, model[1][3]); end
    #2 reset = 1'b1; #1;
    checks++; if ({busy, done, start, sclk_in, low_t, high_t, msg_bit, last_bit, last_msg, restart} !== 10'b0) begin errors++; $display("FAIL async_reset got %b exp 0", {busy, done, start, sclk_in, low_t, high_t, msg_bit, last_bit, last_msg, restart}); end
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      exp = {c % 4 >= 2, c % 4 == 1, c % 4 == 3};
      checks++; if ({sclk_in, high_t, low_t} !== exp) begin errors++; $display("FAIL div_restart c=%0d got %b exp %b", c, {sclk_in, high_t, low_t}, exp); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL no_done c=%0d got %b exp 00", c, {busy, done}); end
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back(model[0][i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); inc_bit = i < 7; #1;
      e = exp_q.pop_front();
      checks++; if (msg_bit !== e) begin errors++; $display("FAIL buf_cleared i=%0d got %b exp %b", i, msg_bit, e); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_strobe i=%0d got %b exp 00", i, {busy, done}); end
    end
    @(negedge clock); inc_bit = 1'b0;
  endtask
  initial begin
    test_reset;
    test_bit_serial;
    test_msg_index;
    test_gap;
    test_illegal_go;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
